vector_deser: RTL and testbench
===============================

// Module: vector_deser
// PURPOSE
//  Serial-to-parallel front end for the vector datapath: assembles WIDTH-bit words from a
//  gated serial stream and presents each word on a registered parallel bus with a
//  valid/ready handshake. data drives the 8-bit data input of vector_Vtop directly.
//  Holds the last delivered word stable until the consumer accepts it; flags overrun.
// PARAMETERS
//  WIDTH      8   bits per word; equals vector_Vtop data width
//  MSB_FIRST  1   1: first serial bit lands in data[WIDTH-1]; 0: first bit lands in data[0]
//  CNT_W      8   width of accepted-word counter
// PORTS
//  clk          in   1        single clock, all state updates on rising edge
//  rst          in   1        asynchronous, active-high reset
//  ser_in       in   1        serial data bit, sampled when ser_en=1
//  ser_en       in   1        bit strobe; one bit consumed per clk with ser_en=1
//  ser_start    in   1        marks the current ser_en bit as bit 0 of a new word
//  data         out  WIDTH    assembled word (registered)
//  data_valid   out  1        data holds an unaccepted word
//  data_ready   in   1        consumer accepts data when data_valid & data_ready
//  overrun      out  1        sticky: a completed word was dropped
//  overrun_clr  in   1        synchronous clear of overrun
//  word_cnt     out  CNT_W    number of accepted words, wraps mod 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, bit_cnt=0, shift reg=0, data=0, data_valid=0,
//   overrun=0, word_cnt=0. All outputs hold these values while rst stays high.
//  States: IDLE (no word in progress), SHIFT (1..WIDTH-1 bits collected).
//  IDLE: ser_en=1 & ser_start=1 -> capture ser_in as bit 0, bit_cnt=1, -> SHIFT.
//   ser_en=1 & ser_start=0 -> bit ignored. ser_en=0 -> no change.
//  SHIFT: ser_en=1 & ser_start=0 -> capture bit, bit_cnt+1. ser_en=0 -> hold.
//   ser_en=1 & ser_start=1 -> discard partial word; this bit becomes bit 0, bit_cnt=1.
//  Word completion: the edge sampling bit WIDTH-1 completes the word; state -> IDLE,
//   bit_cnt -> 0. If WIDTH=1, the start bit itself completes the word.
//  Completion with output slot free (data_valid=0, or data_valid&data_ready same edge):
//   data <= assembled word, data_valid <= 1 on that same edge (visible next cycle).
//   Latency: data valid in the cycle after the edge that samples the last bit.
//  Completion with slot busy (data_valid=1, data_ready=0): word dropped, data unchanged,
//   overrun <= 1.
//  Handshake: data_valid & data_ready at an edge -> word_cnt+1; data_valid <= 0 unless a
//   word completes on the same edge (then reload, data_valid stays 1).
//  data never changes while data_valid=1 and data_ready=0.
//  overrun: set has priority over overrun_clr on the same edge.
//  word_cnt wraps 2^CNT_W-1 -> 0 without flagging.
//  data_ready while data_valid=0: no effect.
//  Bit order: MSB_FIRST=1 shifts left (new bit into LSB); 0 shifts right (new bit into MSB).
//  Reset mid-word or with a pending word: partial and pending words lost; no output glitch
//   beyond immediate return to reset values.
// STRUCTURE
//  vector_pkg: WIDTH default constant, state encoding constants (ST_IDLE, ST_SHIFT).
//  Sub-module vector_shreg: shift register + bit counter, outputs word and done pulse;
//   vector_deser wraps it with output register, handshake, overrun and word counter.
//  Sits upstream of vector_Vtop; vector_deser.data -> vector_Vtop.data.
// TESTING
//  1. ser_start on bit 0, shift 1,1,1,1,0,0,1,1 (MSB_FIRST) -> data=8'hF3, data_valid=1
//     one cycle after 8th bit; data_ready=1 -> data_valid=0, word_cnt=1.
//  2. Back-to-back 8'hAA then 8'h55 with data_ready tied 1 -> two valid pulses,
//     data=AA then 55, word_cnt=2, overrun=0.
//  3. 8'h6D pending, data_ready=0, send 8'hFC -> data stays 6D, overrun=1;
//     overrun_clr -> overrun=0; accept -> word_cnt+1.
//  4. 8'h55 pending, accept on the same edge 8'hFC completes -> data=FC, data_valid stays 1,
//     overrun=0.
//  5. 4 bits of a word, then ser_start re-asserted, shift 8'hAA -> data=8'hAA;
//     ser_en gaps mid-word -> same result; bits with ser_en=0 ignored.
//  6. rst pulse with 5 bits shifted and a word pending -> all outputs 0 immediately;
//     next full word 8'hF3 delivered correctly.

Source files
------------

// File: rtl/vector_pkg.sv
// vector_pkg: shared constants and state encoding for the vector deserializer.
package vector_pkg;
    localparam int VEC_WIDTH = 8;
    localparam int VEC_CNT_W = 8;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/vector_shreg.sv
// vector_shreg: shift register and bit counter; o_word/o_done show the word completed on this edge.
module vector_shreg
    import vector_pkg::*;
#(
    parameter int WIDTH     = VEC_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bit,
    input  logic             i_en,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_word,
    output logic             o_done
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    state_t           r_state, w_state_nx;
    logic [BW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sh, w_base;
    logic             w_take, w_last;
    assign w_take = i_en & (i_start | (r_state == ST_SHIFT));
    assign w_last = w_take & (i_start ? (WIDTH == 1) : (r_cnt == BW'(WIDTH - 1)));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_take) begin
                r_sh  <= o_word;
                r_cnt <= w_last ? '0 : (i_start ? BW'(1) : r_cnt + BW'(1));
            end
        end
    end
    always_comb begin
        w_state_nx = w_take ? (w_last ? ST_IDLE : ST_SHIFT) : r_state;
    end
    // A start bit restarts from an empty register so no partial bits leak in.
    always_comb begin
        w_base = i_start ? '0 : r_sh;
        o_word = MSB_FIRST ? ((w_base << 1) | WIDTH'(i_bit))
                           : ((w_base >> 1) | (WIDTH'(i_bit) << (WIDTH - 1)));
        o_done = w_last;
    end
endmodule

// File: rtl/vector_deser.sv
// vector_deser: serial-to-parallel front end with valid/ready output slot,
// sticky overrun flag and accepted-word counter.
module vector_deser
    import vector_pkg::*;
#(
    parameter int WIDTH     = VEC_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = VEC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_en,
    input  logic             ser_start,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic [CNT_W-1:0] word_cnt
);
    logic [WIDTH-1:0] w_word, r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_done, w_free, w_load, r_valid, r_ovr;
    vector_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_bit   (ser_in),
        .i_en    (ser_en),
        .i_start (ser_start),
        .o_word  (w_word),
        .o_done  (w_done)
    );
    // Slot is free when empty or being drained on this same edge.
    assign w_free = ~r_valid | data_ready;
    assign w_load = w_done & w_free;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_load) r_data <= w_word;
            r_valid <= w_load | (r_valid & ~data_ready);
            r_ovr   <= (w_done & ~w_free) | (r_ovr & ~overrun_clr);
            if (r_valid & data_ready) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
    assign data       = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_ovr;
    assign word_cnt   = r_cnt;
endmodule

// File: tb/tb_vector_deser.sv
// tb_vector_deser: directed checks of word assembly, handshake, overrun, restart and reset.
module tb_vector_deser;
    logic       clk = 1'b0, rst = 1'b1;
    logic       ser_in = 1'b0, ser_en = 1'b0, ser_start = 1'b0;
    logic       data_ready = 1'b0, overrun_clr = 1'b0;
    logic [7:0] data, word_cnt;
    logic       data_valid, overrun;
    int         checks = 0, errors = 0;

    vector_deser dut (
        .clk         (clk),
        .rst         (rst),
        .ser_in      (ser_in),
        .ser_en      (ser_en),
        .ser_start   (ser_start),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        ser_in = b;
        ser_start = s;
        ser_en = 1'b1;
        tick(1);
        ser_en = 1'b0;
        ser_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], i == 7);
    endtask

    initial begin
        #2;
        chk("rst_data", data, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_cnt", word_cnt, 0);
        #10 rst = 1'b0;
        tick(1);
        // 1: F3 MSB first, latency and accept
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hF3 >> i), i == 7);
        chk("t1_valid_early", data_valid, 0);
        send_bit(1'b1, 1'b0);
        chk("t1_data", data, 8'hF3);
        chk("t1_valid", data_valid, 1);
        data_ready = 1'b1;
        tick(1);
        chk("t1_drain", data_valid, 0);
        chk("t1_cnt", word_cnt, 1);
        // 2: back to back with ready held high
        send_word(8'hAA);
        chk("t2_data_aa", data, 8'hAA);
        chk("t2_valid_aa", data_valid, 1);
        send_word(8'h55);
        chk("t2_data_55", data, 8'h55);
        chk("t2_cnt_mid", word_cnt, 2);
        tick(1);
        chk("t2_cnt", word_cnt, 3);
        chk("t2_valid", data_valid, 0);
        chk("t2_ovr", overrun, 0);
        data_ready = 1'b0;
        // 3: overrun on busy slot, clear, accept
        send_word(8'h6D);
        send_word(8'hFC);
        chk("t3_data", data, 8'h6D);
        chk("t3_ovr", overrun, 1);
        chk("t3_valid", data_valid, 1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("t3_ovr_clr", overrun, 0);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        chk("t3_cnt", word_cnt, 4);
        chk("t3_valid_off", data_valid, 0);
        // 4: accept and completion on the same edge
        send_word(8'h55);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hFC >> i), i == 7);
        data_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        data_ready = 1'b0;
        chk("t4_data", data, 8'hFC);
        chk("t4_valid", data_valid, 1);
        chk("t4_ovr", overrun, 0);
        chk("t4_cnt", word_cnt, 5);
        // overrun set wins over a simultaneous clear
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hAA >> i), i == 7);
        overrun_clr = 1'b1;
        send_bit(1'b0, 1'b0);
        overrun_clr = 1'b0;
        chk("prio_ovr", overrun, 1);
        chk("prio_data", data, 8'hFC);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("prio_clr", overrun, 0);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        chk("prio_cnt", word_cnt, 6);
        // 5: restart mid-word, then gapped word with noise on idle strobes
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'(8'hAA >> i), i == 7);
            ser_in = ~ser_in;
            ser_start = 1'b1;
            tick(1);
            ser_start = 1'b0;
        end
        chk("t5_data", data, 8'hAA);
        chk("t5_valid", data_valid, 1);
        chk("t5_ovr", overrun, 0);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        chk("t5_cnt", word_cnt, 7);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        chk("idle_ignored", data_valid, 0);
        send_word(8'h3C);
        chk("idle_data", data, 8'h3C);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        chk("idle_cnt", word_cnt, 8);
        // 6: async reset with a pending word and a partial word
        send_word(8'h81);
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        chk("t6_pre_valid", data_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_data", data, 0);
        chk("t6_valid", data_valid, 0);
        chk("t6_cnt", word_cnt, 0);
        chk("t6_ovr", overrun, 0);
        #1 rst = 1'b0;
        tick(1);
        send_word(8'hF3);
        chk("t6_after", data, 8'hF3);
        chk("t6_after_valid", data_valid, 1);
        data_ready = 1'b1;
        tick(1);
        chk("t6_after_cnt", word_cnt, 1);
        // counter wrap: 255 further words bring it to 256 mod 256
        for (int k = 0; k < 255; k++) send_word(8'(k));
        tick(1);
        chk("wrap_cnt", word_cnt, 0);
        chk("wrap_data", data, 8'hFE);
        chk("wrap_ovr", overrun, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
